// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side and channel-side signals of uart_tx_arbiter.
//   req_string : NUM_REQ*STR_W flattened strings, requester i at [i*STR_W +: STR_W]
//   req_length : NUM_REQ*8 flattened byte counts, requester i at [i*8 +: 8]
//   req_valid  : per-requester pending flag, held until req_ack
//   req_ack    : one-cycle pulse, request latched
//   req_done   : one-cycle pulse, string transmitted / skipped / aborted
//   tx_string, tx_length, tx_req : launch side towards uart_string_handle
//   tx_busy, tx_done             : status from uart_string_handle
//   grant_id   : index of the current or last granted requester
//   arb_busy   : high while the arbiter is outside IDLE
// Modports: master = the arbiter, slave = requesters plus downstream channel.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int STR_BYTES = 128
);
  localparam int STR_W = 8 * STR_BYTES;

  logic [NUM_REQ*STR_W-1:0] req_string;
  logic [NUM_REQ*8-1:0]     req_length;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ack;
  logic [NUM_REQ-1:0]       req_done;
  logic [STR_W-1:0]         tx_string;
  logic [7:0]               tx_length;
  logic                     tx_req;
  logic                     tx_busy;
  logic                     tx_done;
  logic [2:0]               grant_id;
  logic                     arb_busy;

  modport master (
    input  req_string, req_length, req_valid, tx_busy, tx_done,
    output req_ack, req_done, tx_string, tx_length, tx_req, grant_id, arb_busy
  );

  modport slave (
    output req_string, req_length, req_valid, tx_busy, tx_done,
    input  req_ack, req_done, tx_string, tx_length, tx_req, grant_id, arb_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin sharing of one uart_string_handle transmit channel among
// NUM_REQ string producers. One transfer at a time: grant, latch the string,
// pulse tx_req, wait for tx_done, then move the round-robin pointer.
//
// Ports:
//   sys_clk     : system clock
//   sys_rst_n   : asynchronous active-low reset
//   timeout_err : sticky watchdog flag (only with UART_TX_ARB_TIMEOUT_EN)
//   bus         : uart_tx_arbiter_if.master (requester and channel signals)
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog
// of TIMEOUT_CYCLES cycles and the timeout_err output. Without it WAIT_DONE
// waits for tx_done indefinitely.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int STR_BYTES      = 128,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
`ifdef UART_TX_ARB_TIMEOUT_EN
  output logic timeout_err,
`endif
  uart_tx_arbiter_if.master bus
);
  localparam int STR_W = 8 * STR_BYTES;

  if (NUM_REQ < 2 || NUM_REQ > 8 || STR_BYTES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, FINISH} state_t;

  state_t             state, state_nxt;
  logic [2:0]         rr_ptr;
  logic [2:0]         grant_id_q;
  logic [2:0]         win;
  logic               win_found;
  logic [7:0]         valid8;
  logic [7:0]         len_sel;
  logic [STR_W-1:0]   tx_string_q;
  logic [7:0]         tx_length_q;
  logic               done_pend;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] ack_c;
  logic [NUM_REQ-1:0] done_c;
  logic               tx_req_c;
  logic               timeout_hit;

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    if (int'(len) > STR_BYTES) return 8'(STR_BYTES);
    return len;
  endfunction

  // Zero-extend to 8 bits so a 3-bit index always matches the select width.
  assign valid8   = 8'(bus.req_valid);
  assign grant_oh = NUM_REQ'(8'd1 << grant_id_q);
  assign len_sel  = bus.req_length[int'(win)*8 +: 8];

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [3:0] idx;
    idx       = '0;
    win       = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!win_found && valid8[idx[2:0]]) begin
        win_found = 1'b1;
        win       = idx[2:0];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_c     = '0;
    done_c    = '0;
    tx_req_c  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found && !bus.tx_busy) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        ack_c = grant_oh;
        // Empty strings never reach the channel; complete them immediately.
        if (tx_length_q == 8'd0) begin
          done_c    = grant_oh;
          state_nxt = FINISH;
        end else begin
          tx_req_c  = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done || timeout_hit) state_nxt = FINISH;
      end
      FINISH: begin
        // Zero-length grants already reported done in LAUNCH.
        if (done_pend) done_c = grant_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_string_q <= '0;
      tx_length_q <= '0;
      grant_id_q  <= '0;
      rr_ptr      <= '0;
      done_pend   <= 1'b0;
    end else begin
      done_pend <= (state == WAIT_DONE);
      if (state == IDLE && state_nxt == LAUNCH) begin
        tx_string_q <= bus.req_string[int'(win)*STR_W +: STR_W];
        tx_length_q <= clamp_len(len_sel);
        grant_id_q  <= win;
      end
      if (state == FINISH)
        rr_ptr <= (grant_id_q == 3'(NUM_REQ-1)) ? 3'd0 : grant_id_q + 3'd1;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt;

  // Fires on the edge where the count would reach TIMEOUT_CYCLES-1, so
  // req_done lands TIMEOUT_CYCLES cycles after the LAUNCH cycle.
  assign timeout_hit = (state == WAIT_DONE) && !bus.tx_done && (to_cnt + 32'd1 == TO_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == LAUNCH)         to_cnt <= '0;
      else if (state == WAIT_DONE) to_cnt <= to_cnt + 32'd1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign bus.req_ack   = ack_c;
  assign bus.req_done  = done_c;
  assign bus.tx_req    = tx_req_c;
  assign bus.tx_string = tx_string_q;
  assign bus.tx_length = tx_length_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.arb_busy  = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Table of single transfers (mask, lengths, busy hold, expected winner and
// clamped length) plus hand-written reset, withdrawal and timeout sequences.
// Expected grants are queued when a request is driven and popped by a
// monitor when req_ack appears.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NUM_REQ        = 4;
  localparam int STR_BYTES      = 128;
  localparam int STR_W          = 8 * STR_BYTES;
  localparam int TIMEOUT_CYCLES = 100;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .STR_BYTES(STR_BYTES)) bus ();

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .STR_BYTES(STR_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
`ifdef UART_TX_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .bus(bus.master)
  );

  typedef struct {
    int          id;
    logic [7:0]  len;
    logic [STR_W-1:0] str;
  } exp_t;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] lens;
    int          busy;
    int          delay;
    int          exp_id;
    int          exp_len;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  logic [STR_W-1:0] strs[NUM_REQ];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Grant monitor: every ack must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n && bus.req_ack != '0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got %0h required 0", bus.req_ack);
      end else begin
        e = sb.pop_front();
        chk("ack_onehot", 64'(bus.req_ack), 64'(4'b0001 << e.id));
        chk("grant_id",   64'(bus.grant_id), 64'(e.id));
        chk("tx_length",  64'(bus.tx_length), 64'(e.len));
        chk("tx_req",     64'(bus.tx_req), 64'(e.len != 8'd0));
        chk("tx_string",  64'(bus.tx_string == e.str), 64'd1);
      end
    end else if (sys_rst_n && bus.tx_req) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_req_without_ack: got 1 required 0");
    end
  end

  task automatic push_exp(input int id, input int len);
    exp_t e;
    e.id  = id;
    e.len = 8'(len);
    e.str = strs[id];
    sb.push_back(e);
  endtask

  // Waits for req_ack; returns the number of negedges waited, or 0 if no ack arrived.
  task automatic wait_ack(input int limit, input int busy, output int lat);
    lat = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge sys_clk);
      if (bus.req_ack != '0) begin
        lat = c;
        break;
      end
      if (c == busy) bus.tx_busy = 1'b0;
    end
    if (lat == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got none required ack within %0d cycles", limit);
      sb.delete();
    end
  endtask

  task automatic do_xfer(input vec_t v);
    int lat;
    logic [3:0] oh;
    oh = 4'(4'b0001 << v.exp_id);
    push_exp(v.exp_id, v.exp_len);
    bus.req_length = v.lens;
    bus.req_valid  = v.mask;
    bus.tx_busy    = (v.busy > 0);
    wait_ack(v.busy + 20, v.busy, lat);
    if (lat != 0) begin
      chk("ack_latency", 64'(lat), 64'(v.busy + 1));
      if (v.exp_len == 0) begin
        chk("done_with_ack", 64'(bus.req_done), 64'(oh));
        @(negedge sys_clk);
        chk("done_after_zero", 64'(bus.req_done), 64'd0);
      end else begin
        chk("done_early", 64'(bus.req_done), 64'd0);
        repeat (v.delay) begin
          @(negedge sys_clk);
          chk("wait_quiet", 64'({bus.tx_req, bus.req_done}), 64'd0);
        end
        bus.tx_done = 1'b1;
        @(negedge sys_clk);
        chk("req_done", 64'(bus.req_done), 64'(oh));
        bus.tx_done = 1'b0;
      end
      @(negedge sys_clk);
      chk("arb_idle", 64'(bus.arb_busy), 64'd0);
    end
    bus.req_valid = '0;
    bus.tx_busy   = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    vec_t hv;

    for (int i = 0; i < NUM_REQ; i++)
      for (int w = 0; w < STR_W/32; w++)
        strs[i][w*32 +: 32] = $urandom;
    strs[2][47:0] = 48'h0D_6F_6C_6C_65_68; // "hello\r", first byte lowest

    bus.req_valid  = '0;
    bus.req_length = '0;
    bus.tx_busy    = 1'b0;
    bus.tx_done    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_string[i*STR_W +: STR_W] = strs[i];

    //          mask     lens(r3 r2 r1 r0)  busy dly id len
    vecs[0]  = '{4'b1111, 32'h28_05_14_0A, 0, 2, 0, 10};
    vecs[1]  = '{4'b1111, 32'h28_05_14_0A, 0, 1, 1, 20};
    vecs[2]  = '{4'b1111, 32'h28_05_14_0A, 0, 3, 2, 5};
    vecs[3]  = '{4'b1111, 32'h28_05_14_0A, 0, 1, 3, 40};
    vecs[4]  = '{4'b1111, 32'h28_05_14_0A, 0, 2, 0, 10};
    vecs[5]  = '{4'b0100, 32'h00_05_00_00, 0, 4, 2, 5};
    vecs[6]  = '{4'b0010, 32'h00_00_00_00, 0, 1, 1, 0};
    vecs[7]  = '{4'b1000, 32'hC8_00_00_00, 4, 2, 3, 128};
    vecs[8]  = '{4'b1010, 32'h07_00_09_00, 0, 1, 1, 9};
    vecs[9]  = '{4'b1010, 32'h07_00_09_00, 0, 1, 3, 7};
    vecs[10] = '{4'b0001, 32'h00_00_00_80, 0, 1, 0, 128};
    vecs[11] = '{4'b0001, 32'h00_00_00_81, 0, 1, 0, 128};

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_tx_req",    64'(bus.tx_req), 64'd0);
    chk("rst_req_ack",   64'(bus.req_ack), 64'd0);
    chk("rst_req_done",  64'(bus.req_done), 64'd0);
    chk("rst_grant_id",  64'(bus.grant_id), 64'd0);
    chk("rst_tx_length", 64'(bus.tx_length), 64'd0);
    chk("rst_arb_busy",  64'(bus.arb_busy), 64'd0);
    chk("rst_tx_string", 64'(bus.tx_string == '0), 64'd1);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 12; i++) do_xfer(vecs[i]);

    // Reset during WAIT_DONE: pointer is 1 here, so a post-reset 1001 mask
    // only picks requester 0 if the pointer really returned to 0.
    push_exp(0, 3);
    bus.req_length = 32'h00_00_00_03;
    bus.req_valid  = 4'b0001;
    wait_ack(20, 0, lat);
    bus.req_valid = '0;
    @(negedge sys_clk);
    chk("mid_arb_busy", 64'(bus.arb_busy), 64'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_arb_busy",  64'(bus.arb_busy), 64'd0);
    chk("arst_grant_id",  64'(bus.grant_id), 64'd0);
    chk("arst_tx_length", 64'(bus.tx_length), 64'd0);
    chk("arst_req_done",  64'(bus.req_done), 64'd0);
    chk("arst_tx_string", 64'(bus.tx_string == '0), 64'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    // tx_done while idle must be ignored.
    bus.tx_done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      bus.tx_done = 1'b0;
      chk("post_rst_quiet", 64'({bus.arb_busy, bus.req_done}), 64'd0);
    end
    hv = '{4'b1001, 32'h06_00_00_04, 0, 2, 0, 4};
    do_xfer(hv);

    // Withdrawn request: valid drops while tx_busy blocks the grant.
    bus.tx_busy   = 1'b1;
    bus.req_valid = 4'b0100;
    repeat (3) @(negedge sys_clk);
    bus.req_valid = '0;
    bus.tx_busy   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      chk("withdrawn_no_grant", 64'({bus.arb_busy, bus.req_ack}), 64'd0);
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("timeout_err_clear", 64'(timeout_err), 64'd0);
    push_exp(2, 5);
    bus.req_length = 32'h00_05_00_00;
    bus.req_valid  = 4'b0100;
    wait_ack(20, 0, lat);
    bus.req_valid = '0;
    cnt = 0;
    for (int c = 1; c <= 3*TIMEOUT_CYCLES; c++) begin
      @(negedge sys_clk);
      if (bus.req_done != '0) begin
        cnt = c;
        break;
      end
    end
    chk("timeout_latency", 64'(cnt), 64'(TIMEOUT_CYCLES));
    chk("timeout_done",    64'(bus.req_done), 64'h4);
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    repeat (3) @(negedge sys_clk);
    chk("timeout_err_sticky", 64'(timeout_err), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
